mux_pair_loader: RTL and testbench
==================================

# mux_pair_loader

Upstream stage of the 10-bit two-input selector. Accepts a stream of 10-bit words over a valid/ready handshake, captures them as an ordered pair onto `input1`/`input2`, then drives `select` to alternate between the two for a programmable number of cycles each. Runs until cleared, then accepts a new pair.

## Interface
- `WIDTH`, 10, data word width; matches the selector's data inputs.
- `HOLD_W`, 8, width of the hold-count input.
- `TIMEOUT`, 255, cycles allowed between first and second word (only with `MUX_LOADER_TIMEOUT_EN`).

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `clear`  in  1  synchronous abort to IDLE.
- `data_in`  in  WIDTH  incoming word.
- `data_valid`  in  1  `data_in` is valid.
- `data_ready`  out  1  block can accept a word.
- `hold_cycles`  in  HOLD_W  cycles each selection is held.
- `input1`  out  WIDTH  first captured word, to selector input 1.
- `input2`  out  WIDTH  second captured word, to selector input 2.
- `select`  out  1  0 selects `input1`, 1 selects `input2`.
- `pair_loaded`  out  1  high while a valid pair is presented.
- `timeout_err`  out  1  one-cycle error pulse (only with `MUX_LOADER_TIMEOUT_EN`).

## Operation
- States: IDLE, WAIT_B, RUN_A, RUN_B. All outputs registered.
- Transfer occurs on a rising edge where `data_valid && data_ready` are both high.
- IDLE: `data_ready`=1. On transfer, `input1`<=`data_in` and the block moves to WAIT_B.
- WAIT_B: `data_ready`=1. On transfer, `input2`<=`data_in` and the block moves to RUN_A.
  - The hold counter is loaded with `max(hold_cycles,1)-1`.
  - `pair_loaded`<=1.
- RUN_A: `select`=0, `data_ready`=0. Counter decrements each cycle. At 0, go to RUN_B and reload the counter from `hold_cycles`, sampled at that edge.
- RUN_B: `select`=1. Same counting rule; at 0, return to RUN_A.
- `hold_cycles`=0 is treated as 1, so `select` toggles every cycle.
- `clear` has priority over every other event, including a simultaneous transfer, which is dropped.
  - Next state is IDLE.
  - `input1`, `input2`, `select`, `pair_loaded` and the counter all go to 0.
- `data_valid` while `data_ready`=0 is ignored. The word is not captured.
- `data_ready` is the registered value of (next state is IDLE or WAIT_B).

## Timing
- Reset values:
  - `data_ready`=0, `input1`=0, `input2`=0, `select`=0, `pair_loaded`=0, `timeout_err`=0.
  - State is IDLE.
  - `data_ready` rises on the first edge after `rst_n` deasserts.
- Reset asserted mid-operation returns to IDLE immediately and asynchronously. Captured words are lost.
- `input1` updates 1 cycle after the first transfer.
- `input2`, `pair_loaded` and the RUN_A entry update 1 cycle after the second transfer. `data_ready` falls at the same edge.
- Back-to-back transfers on consecutive cycles are supported: first in IDLE, second in WAIT_B.
- `select` period: each phase lasts exactly `max(hold_cycles,1)` cycles.
- After `clear`: `data_ready`=1 on the following cycle.

## Configuration
- `MUX_LOADER_TIMEOUT_EN` defined:
  - A WAIT_B cycle counter runs while no transfer occurs.
  - After `TIMEOUT` consecutive cycles in WAIT_B without a transfer:
    - state goes to IDLE;
    - `input1`<=0;
    - `timeout_err` pulses high for 1 cycle.
  - A transfer on the expiring cycle wins: no error, and the block goes to RUN_A.
- Not defined:
  - WAIT_B waits indefinitely.
  - The `timeout_err` port and the `TIMEOUT` parameter are absent.

## Structure
- Shared package `mux_loader_pkg`:
  - state enum (IDLE, WAIT_B, RUN_A, RUN_B);
  - `WIDTH`=10 constant;
  - default `HOLD_W`.
- One sub-module, `hold_counter`: a loadable down-counter with a zero flag. It is instantiated for the hold period, and a second time for the timeout when that macro is enabled.

## Test plan
- Reset held 3 cycles, then released:
  - during reset, all outputs = 0;
  - `data_ready`=1 one cycle after release.
- Load pair with `hold_cycles`=3:
  - send 0x155 then 0x2AA on consecutive cycles;
  - `input1`=0x155, `input2`=0x2AA, `pair_loaded`=1;
  - `select` pattern 0,0,0,1,1,1,0 and repeating.
- `hold_cycles`=0 after loading a pair → `select` toggles every cycle.
- `clear` pulsed in RUN_B, with a simultaneous `data_valid`:
  - next cycle: IDLE, `select`=0, `input1`=`input2`=0, `pair_loaded`=0;
  - the word is not captured.
- `data_valid` held high with 0x3FF during RUN_A → no capture; `input2` unchanged.
- Timeout, with macro enabled and `TIMEOUT`=4:
  - send one word, then idle;
  - after 4 cycles, `timeout_err` pulses once, state is IDLE and `input1`=0.

Source files
------------

// File: rtl/mux_loader_pkg.sv
// Shared types and constants for the mux pair loader and its hold counter.
// Optional WAIT_B timeout is enabled with the MUX_LOADER_TIMEOUT_EN macro.
package mux_loader_pkg;

   localparam int LOADER_WIDTH   = 10;
   localparam int DEFAULT_HOLD_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT_B = 2'd1,
      ST_RUN_A  = 2'd2,
      ST_RUN_B  = 2'd3
   } loader_state_t;

endpackage

// File: rtl/mux_pair_loader_hold_counter.sv
// Loadable down-counter with a zero flag; saturates at zero.
// Priority: clr, then load, then dec.
module hold_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/mux_pair_loader.sv
// Captures an ordered word pair, then alternates select between them.
// Define MUX_LOADER_TIMEOUT_EN to abandon a half-loaded pair after TIMEOUT cycles.
module mux_pair_loader
   import mux_loader_pkg::*;
#(
   parameter int WIDTH  = LOADER_WIDTH,
   parameter int HOLD_W = DEFAULT_HOLD_W
`ifdef MUX_LOADER_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 255
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic [WIDTH-1:0]  data_in,
   input  logic              data_valid,
   output logic              data_ready,
   input  logic [HOLD_W-1:0] hold_cycles,
   output logic [WIDTH-1:0]  input1,
   output logic [WIDTH-1:0]  input2,
   output logic              select,
   output logic              pair_loaded,
`ifdef MUX_LOADER_TIMEOUT_EN
   output logic              timeout_err,
`endif
   output loader_state_t     state_dbg
);

   // Handshake: a word transfers on a rising edge where data_valid and
   // data_ready are both high; data_valid while data_ready is low is ignored.
   loader_state_t     state, state_nxt;
   logic              xfer;
   logic              cap1, cap2;
   logic              hc_load, hc_dec, hc_zero;
   logic [HOLD_W-1:0] hc_load_val;

`ifdef MUX_LOADER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);
   logic to_load, to_dec, to_zero, to_fire;
`endif

   assign xfer      = data_valid && data_ready;
   assign state_dbg = state;

   // hold_cycles of 0 behaves like 1 so each phase lasts at least a cycle.
   assign hc_load_val = (hold_cycles == '0) ? '0 : hold_cycles - 1'b1;

   hold_counter #(.W(HOLD_W)) u_hold_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clear),
      .load     (hc_load),
      .load_val (hc_load_val),
      .dec      (hc_dec),
      .zero     (hc_zero)
   );

`ifdef MUX_LOADER_TIMEOUT_EN
   hold_counter #(.W(TO_W)) u_timeout_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clear),
      .load     (to_load),
      .load_val (TO_LOAD),
      .dec      (to_dec),
      .zero     (to_zero)
   );
`endif

   always_comb begin
      state_nxt = state;
      cap1      = 1'b0;
      cap2      = 1'b0;
      hc_load   = 1'b0;
      hc_dec    = 1'b0;
`ifdef MUX_LOADER_TIMEOUT_EN
      to_load   = 1'b0;
      to_dec    = 1'b0;
      to_fire   = 1'b0;
`endif
      if (clear) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (xfer) begin
                  cap1      = 1'b1;
                  state_nxt = ST_WAIT_B;
`ifdef MUX_LOADER_TIMEOUT_EN
                  to_load   = 1'b1;
`endif
               end
            end
            ST_WAIT_B: begin
               if (xfer) begin
                  cap2      = 1'b1;
                  hc_load   = 1'b1;
                  state_nxt = ST_RUN_A;
               end
`ifdef MUX_LOADER_TIMEOUT_EN
               else if (to_zero) begin
                  to_fire   = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  to_dec = 1'b1;
               end
`endif
            end
            ST_RUN_A: begin
               if (hc_zero) begin
                  hc_load   = 1'b1;
                  state_nxt = ST_RUN_B;
               end else begin
                  hc_dec = 1'b1;
               end
            end
            ST_RUN_B: begin
               if (hc_zero) begin
                  hc_load   = 1'b1;
                  state_nxt = ST_RUN_A;
               end else begin
                  hc_dec = 1'b1;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         data_ready  <= 1'b0;
         input1      <= '0;
         input2      <= '0;
         select      <= 1'b0;
         pair_loaded <= 1'b0;
`ifdef MUX_LOADER_TIMEOUT_EN
         timeout_err <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         data_ready  <= (state_nxt == ST_IDLE) || (state_nxt == ST_WAIT_B);
         select      <= (state_nxt == ST_RUN_B);
         pair_loaded <= (state_nxt == ST_RUN_A) || (state_nxt == ST_RUN_B);
`ifdef MUX_LOADER_TIMEOUT_EN
         timeout_err <= to_fire;
`endif
         if (clear) begin
            input1 <= '0;
            input2 <= '0;
         end else begin
            if (cap1) input1 <= data_in;
            if (cap2) input2 <= data_in;
`ifdef MUX_LOADER_TIMEOUT_EN
            if (to_fire) input1 <= '0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_mux_pair_loader.sv
// Directed self-checking bench for mux_pair_loader; inputs driven and outputs
// sampled on the falling edge. Timeout checks use TIMEOUT=4 when enabled.
module tb_mux_pair_loader;
   import mux_loader_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic [9:0]  data_in;
   logic        data_valid;
   logic        data_ready;
   logic [7:0]  hold_cycles;
   logic [9:0]  input1;
   logic [9:0]  input2;
   logic        select;
   logic        pair_loaded;
   loader_state_t state_dbg;
`ifdef MUX_LOADER_TIMEOUT_EN
   logic        timeout_err;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   mux_pair_loader #(
      .WIDTH  (10),
      .HOLD_W (8)
`ifdef MUX_LOADER_TIMEOUT_EN
      ,
      .TIMEOUT(4)
`endif
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .hold_cycles (hold_cycles),
      .input1      (input1),
      .input2      (input2),
      .select      (select),
      .pair_loaded (pair_loaded),
`ifdef MUX_LOADER_TIMEOUT_EN
      .timeout_err (timeout_err),
`endif
      .state_dbg   (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got running, need finished");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic next_neg();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [9:0] d, input logic c);
      data_valid = v;
      data_in    = d;
      clear      = c;
   endtask

   // scoreboard of expected select values, one per falling edge
   logic [0:0] exp_q[$];

   initial begin
      rst_n = 1'b0;
      hold_cycles = 8'd3;
      drive(1'b0, 10'h000, 1'b0);

      for (int i = 0; i < 3; i++) begin
         next_neg();
         check_eq("rst_ready",  {31'd0, data_ready},  32'd0);
         check_eq("rst_in1",    {22'd0, input1},      32'd0);
         check_eq("rst_in2",    {22'd0, input2},      32'd0);
         check_eq("rst_sel",    {31'd0, select},      32'd0);
         check_eq("rst_pair",   {31'd0, pair_loaded}, 32'd0);
         check_eq("rst_state",  32'(state_dbg),       32'(ST_IDLE));
`ifdef MUX_LOADER_TIMEOUT_EN
         check_eq("rst_toerr",  {31'd0, timeout_err}, 32'd0);
`endif
      end
      rst_n = 1'b1;
      next_neg();
      check_eq("ready_after_rst", {31'd0, data_ready}, 32'd1);

      // pair load with hold 3, back-to-back words
      drive(1'b1, 10'h155, 1'b0);
      next_neg();
      check_eq("in1_cap",     {22'd0, input1},     32'h155);
      check_eq("state_waitb", 32'(state_dbg),      32'(ST_WAIT_B));
      check_eq("ready_waitb", {31'd0, data_ready}, 32'd1);
      drive(1'b1, 10'h2AA, 1'b0);
      next_neg();
      check_eq("in2_cap",     {22'd0, input2},      32'h2AA);
      check_eq("pair_set",    {31'd0, pair_loaded}, 32'd1);
      check_eq("ready_runa",  {31'd0, data_ready},  32'd0);

      // data_valid held with 0x3FF while running must not capture
      drive(1'b1, 10'h3FF, 1'b0);
      exp_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 10; i++) begin
         if (i > 0) next_neg();
         check_eq($sformatf("sel_h3_%0d", i), {31'd0, select}, {31'd0, exp_q.pop_front()});
      end
      check_eq("in1_kept", {22'd0, input1}, 32'h155);
      check_eq("in2_kept", {22'd0, input2}, 32'h2AA);

      // hold 0: finishes current 3-cycle RUN_B phase, then toggles every cycle
      hold_cycles = 8'd0;
      exp_q = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 8; i++) begin
         next_neg();
         check_eq($sformatf("sel_h0_%0d", i), {31'd0, select}, {31'd0, exp_q.pop_front()});
      end
      check_eq("state_runb", 32'(state_dbg), 32'(ST_RUN_B));

      // clear in RUN_B with simultaneous data_valid
      drive(1'b1, 10'h0AB, 1'b1);
      next_neg();
      drive(1'b0, 10'h000, 1'b0);
      check_eq("clr_state", 32'(state_dbg),       32'(ST_IDLE));
      check_eq("clr_sel",   {31'd0, select},      32'd0);
      check_eq("clr_in1",   {22'd0, input1},      32'd0);
      check_eq("clr_in2",   {22'd0, input2},      32'd0);
      check_eq("clr_pair",  {31'd0, pair_loaded}, 32'd0);
      check_eq("clr_ready", {31'd0, data_ready},  32'd1);
      next_neg();
      check_eq("clr_nocap", {22'd0, input1},      32'd0);

      // clear beats a simultaneous accepted transfer in WAIT_B
      drive(1'b1, 10'h123, 1'b0);
      next_neg();
      check_eq("in1_second", {22'd0, input1}, 32'h123);
      drive(1'b1, 10'h321, 1'b1);
      next_neg();
      drive(1'b0, 10'h000, 1'b0);
      check_eq("clrx_state", 32'(state_dbg),       32'(ST_IDLE));
      check_eq("clrx_in1",   {22'd0, input1},      32'd0);
      check_eq("clrx_in2",   {22'd0, input2},      32'd0);
      check_eq("clrx_pair",  {31'd0, pair_loaded}, 32'd0);

      // single word then idle
      drive(1'b1, 10'h0F0, 1'b0);
      next_neg();
      drive(1'b0, 10'h000, 1'b0);
      check_eq("to_in1", {22'd0, input1}, 32'h0F0);
`ifdef MUX_LOADER_TIMEOUT_EN
      for (int i = 0; i < 3; i++) begin
         next_neg();
         check_eq($sformatf("to_wait_%0d", i), 32'(state_dbg), 32'(ST_WAIT_B));
         check_eq($sformatf("to_err0_%0d", i), {31'd0, timeout_err}, 32'd0);
      end
      next_neg();
      check_eq("to_pulse", {31'd0, timeout_err}, 32'd1);
      check_eq("to_idle",  32'(state_dbg),       32'(ST_IDLE));
      check_eq("to_in1_0", {22'd0, input1},      32'd0);
      next_neg();
      check_eq("to_once",  {31'd0, timeout_err}, 32'd0);
`else
      for (int i = 0; i < 6; i++) begin
         next_neg();
         check_eq($sformatf("wait_%0d", i), 32'(state_dbg), 32'(ST_WAIT_B));
      end
      check_eq("wait_in1", {22'd0, input1},     32'h0F0);
      check_eq("wait_rdy", {31'd0, data_ready}, 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
